// File: rtl/ibex_rf_access_arbiter.sv
// Shares the register file write port and read port B between the core pipeline
// and an external requester; the core always wins, and starvation forces a core stall.
module ibex_rf_access_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_rb_used_i,
  input  logic [4:0]           core_raddr_b_i,
  output logic                 core_stall_o,

  input  logic                 ext_req_i,
  input  logic                 ext_we_i,
  input  logic [4:0]           ext_addr_i,
  input  logic [DataWidth-1:0] ext_wdata_i,
  output logic                 ext_gnt_o,
  output logic                 ext_rvalid_o,
  output logic [DataWidth-1:0] ext_rdata_o,
  output logic                 ext_err_o,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [4:0]           rf_raddr_b_o,
  input  logic [DataWidth-1:0] rf_rdata_b_i
);

  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 8;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 hold_we_q;
  logic [AddrW-1:0]     hold_addr_q;
  logic [DataWidth-1:0] hold_wdata_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 stall_q, stall_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 gnt;
  logic                 capture;

  logic                 in_pend;
  logic                 addr_illegal;
  logic                 wr_x0;
  logic                 port_free;
  logic                 ext_wr_access;
  logic                 ext_rd_access;
  logic                 complete;

  // Decode of the held request against the current core port usage
  always_comb begin
    in_pend       = (state_q == PEND);
    addr_illegal  = RV32E && hold_addr_q[4];
    wr_x0         = hold_we_q && (hold_addr_q == '0);
    port_free     = hold_we_q ? !core_we_i : !core_rb_used_i;
    ext_wr_access = in_pend && !addr_illegal && !wr_x0 && hold_we_q && port_free;
    ext_rd_access = in_pend && !addr_illegal && !hold_we_q && port_free;
    // Illegal addresses and x0 writes never touch the RF, so they never wait
    complete      = in_pend && (addr_illegal || wr_x0 || port_free);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt      = 1'b0;
    capture  = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = ext_req_i;
        if (ext_req_i) begin
          capture = 1'b1;
          cnt_d   = '0;
          stall_d = 1'b0;
          state_d = PEND;
        end
      end
      PEND: begin
        if (complete) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          stall_d  = 1'b0;
          err_d    = addr_illegal;
          rdata_d  = ext_rd_access ? rf_rdata_b_i : '0;
        end else begin
          if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + CntW'(1);
          end
          stall_d = (cnt_d == MaxCnt);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (capture) begin
        hold_we_q    <= ext_we_i;
        hold_addr_q  <= ext_addr_i;
        hold_wdata_q <= ext_wdata_i;
      end
    end
  end

  // State is forced to IDLE while in reset, but the grant must also be masked then
  assign ext_gnt_o    = gnt && rst_ni;
  assign ext_rvalid_o = rvalid_q;
  assign ext_rdata_o  = rdata_q;
  assign ext_err_o    = err_q;
  assign core_stall_o = stall_q;

  assign rf_we_o      = core_we_i || ext_wr_access;
  assign rf_waddr_o   = ext_wr_access ? hold_addr_q  : core_waddr_i;
  assign rf_wdata_o   = ext_wr_access ? hold_wdata_q : core_wdata_i;
  assign rf_raddr_b_o = ext_rd_access ? hold_addr_q  : core_raddr_b_i;

endmodule

// File: tb/tb_ibex_rf_access_arbiter.sv
// Randomized bench for ibex_rf_access_arbiter against a transaction-level model
// of request, wait, access and response, with a behavioural register file attached.
module tb_ibex_rf_access_arbiter;

  localparam int unsigned DW       = 32;
  localparam int unsigned MaxWaitP = 4;
  localparam bit          Rv32eP   = 1'b1;

  logic          clk;
  logic          rst_n;
  logic          core_we;
  logic [4:0]    core_waddr;
  logic [DW-1:0] core_wdata;
  logic          core_rb_used;
  logic [4:0]    core_raddr_b;
  logic          core_stall;
  logic          ext_req;
  logic          ext_we;
  logic [4:0]    ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          ext_err;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    rf_raddr_b;
  logic [DW-1:0] rf_rdata_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibex_rf_access_arbiter #(
    .RV32E    (Rv32eP),
    .DataWidth(DW),
    .MaxWait  (MaxWaitP)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .core_we_i     (core_we),
    .core_waddr_i  (core_waddr),
    .core_wdata_i  (core_wdata),
    .core_rb_used_i(core_rb_used),
    .core_raddr_b_i(core_raddr_b),
    .core_stall_o  (core_stall),
    .ext_req_i     (ext_req),
    .ext_we_i      (ext_we),
    .ext_addr_i    (ext_addr),
    .ext_wdata_i   (ext_wdata),
    .ext_gnt_o     (ext_gnt),
    .ext_rvalid_o  (ext_rvalid),
    .ext_rdata_o   (ext_rdata),
    .ext_err_o     (ext_err),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_raddr_b_o  (rf_raddr_b),
    .rf_rdata_b_i  (rf_rdata_b)
  );

  // Behavioural register file on the arbitrated ports
  logic          rf_clear;
  logic [DW-1:0] rf_mem [32];
  assign rf_rdata_b = rf_mem[rf_raddr_b];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  typedef struct packed {
    logic          we;
    logic [4:0]    addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          req_q[$];
  int            gnt_cycles[$];

  // Model: outstanding transaction, blocked cycles so far, response pending
  bit            m_active;
  req_t          m_txn;
  int            m_waited;
  bit            m_resp;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  logic [DW-1:0] m_mem [32];

  logic          s_we;
  logic [4:0]    s_waddr;
  logic [DW-1:0] s_wdata;
  logic          s_rb;
  logic [4:0]    s_raddr;
  bit            s_rst;

  int cyc;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit we, input int addr, input logic [DW-1:0] data);
    req_t r;
    r.we    = we;
    r.addr  = 5'(addr);
    r.wdata = data;
    req_q.push_back(r);
  endtask

  // One clock cycle: drive, predict, sample at negedge, advance model at the edge
  task automatic cycle();
    bit            exp_gnt, exp_stall, legal, needs_port, free, acc;
    logic          exp_rf_we;
    logic [4:0]    exp_waddr, exp_raddr;
    logic [DW-1:0] exp_wdata, rd;

    if (s_rst) begin
      m_active = 1'b0;
      m_resp   = 1'b0;
      m_rdata  = '0;
      m_err    = 1'b0;
      m_waited = 0;
    end
    exp_stall    = m_active && (m_waited >= int'(MaxWaitP));
    rst_n        = !s_rst;
    core_we      = s_we && !exp_stall;
    core_waddr   = s_waddr;
    core_wdata   = s_wdata;
    core_rb_used = s_rb && !exp_stall;
    core_raddr_b = s_raddr;
    ext_req      = (req_q.size() > 0);
    if (ext_req) begin
      ext_we    = req_q[0].we;
      ext_addr  = req_q[0].addr;
      ext_wdata = req_q[0].wdata;
    end else begin
      ext_we    = 1'($urandom);
      ext_addr  = 5'($urandom);
      ext_wdata = $urandom;
    end

    legal      = !(Rv32eP && m_txn.addr[4]);
    needs_port = m_active && legal && !(m_txn.we && (m_txn.addr == 5'd0));
    free       = m_txn.we ? !core_we : !core_rb_used;
    acc        = m_active && (!needs_port || free);
    exp_gnt    = !s_rst && !m_active && !m_resp && ext_req;

    exp_rf_we = core_we;
    exp_waddr = core_waddr;
    exp_wdata = core_wdata;
    exp_raddr = core_raddr_b;
    if (acc && needs_port && m_txn.we) begin
      exp_rf_we = 1'b1;
      exp_waddr = m_txn.addr;
      exp_wdata = m_txn.wdata;
    end
    if (acc && needs_port && !m_txn.we) exp_raddr = m_txn.addr;

    @(negedge clk);
    check("gnt",    64'(ext_gnt),    64'(exp_gnt));
    check("rvalid", 64'(ext_rvalid), 64'(m_resp));
    check("stall",  64'(core_stall), 64'(exp_stall));
    check("rdata",  64'(ext_rdata),  64'(m_rdata));
    check("err",    64'(ext_err),    64'(m_err));
    check("rf_we",  64'(rf_we),      64'(exp_rf_we));
    if (exp_rf_we) begin
      check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
    end
    check("rf_raddr_b", 64'(rf_raddr_b), 64'(exp_raddr));
    if (ext_gnt) gnt_cycles.push_back(cyc);

    rd = m_mem[m_txn.addr];
    if (exp_rf_we) m_mem[exp_waddr] = exp_wdata;
    m_resp = 1'b0;
    if (acc) begin
      m_active = 1'b0;
      m_resp   = 1'b1;
      m_err    = !legal;
      m_rdata  = (needs_port && !m_txn.we) ? rd : '0;
    end else if (m_active) begin
      m_waited++;
    end
    if (exp_gnt) begin
      m_active = 1'b1;
      m_txn    = req_q.pop_front();
      m_waited = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    rf_clear = 1'b1;
    m_active = 1'b0;
    m_resp   = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    m_waited = 0;
    m_txn    = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_rb = 1'b0; s_raddr = '0;
    s_rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, including a request held during reset
    cycle();
    rf_clear = 1'b0;
    push(1'b1, 5, 32'hDEADBEEF);
    cycle();
    s_rst = 1'b0;

    // Idle core: write then read back x5
    run(4);
    push(1'b0, 5, 32'h0);
    run(4);
    check("x5_readback", 64'(ext_rdata), 64'(32'hDEADBEEF));
    check("x5_err", 64'(ext_err), 64'(0));

    // Core write occupies the port for three cycles during a pending ext write
    push(1'b1, 7, 32'h1234_5678);
    cycle();
    s_we = 1'b1; s_waddr = 5'd3; s_wdata = 32'hCAFE_0003;
    run(3);
    s_we = 1'b0;
    run(4);

    // Starved read: stall rises after MaxWait blocked cycles
    s_rb = 1'b1; s_raddr = 5'd9;
    push(1'b0, 7, 32'h0);
    run(10);
    s_rb = 1'b0;
    check("x7_readback", 64'(ext_rdata), 64'(32'h1234_5678));

    // Illegal RV32E address and write to x0
    push(1'b0, 20, 32'h0);
    run(4);
    check("illegal_err", 64'(ext_err), 64'(1));
    push(1'b1, 0, 32'h1);
    run(4);

    // Reset while PEND drops the transaction
    s_rb = 1'b1;
    push(1'b0, 3, 32'h0);
    run(2);
    s_rst = 1'b1;
    cycle();
    s_rst = 1'b0;
    s_rb = 1'b0;
    run(2);
    push(1'b0, 3, 32'h0);
    run(4);

    // Back-to-back requests with an idle core
    gnt_cycles.delete();
    for (int i = 0; i < 4; i++) push(i[0], 4 + i, $urandom);
    run(14);
    check("b2b_count", 64'(gnt_cycles.size()), 64'(4));
    for (int i = 1; i < gnt_cycles.size(); i++)
      check("b2b_spacing", 64'(gnt_cycles[i] - gnt_cycles[i-1]), 64'(3));

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      s_we    = ($urandom_range(0, 2) == 0);
      s_waddr = 5'($urandom);
      s_wdata = $urandom;
      s_rb    = ($urandom_range(0, 3) != 0) && (i % 400 < 300);
      s_raddr = 5'($urandom);
      s_rst   = ($urandom_range(0, 249) == 0);
      if (req_q.size() == 0 && $urandom_range(0, 3) == 0)
        push(1'($urandom), $urandom_range(0, 31), $urandom);
      cycle();
    end
    s_rst = 1'b0;
    s_we  = 1'b0;
    s_rb  = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
